// File: rtl/core_seq.sv
// Instruction sequencer for one conv layer on core: per-kij weight/activation fill,
// execute, ofifo drain to psum memory, then SFP accumulation over output pixels.
module core_seq #(
  parameter int unsigned row      = 8,
  parameter int unsigned col      = 8,
  parameter int unsigned len_nij  = 36,
  parameter int unsigned len_onij = 16,
  parameter int unsigned len_kij  = 9,
  parameter int unsigned addr_bw  = 11,
  parameter int unsigned w_base   = 1024,
  parameter int unsigned gap      = 10
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [1:0]                                         mode,
  input  logic                                               ofifo_valid,
  input  logic [addr_bw-1:0]                                 acc_addr,
  input  logic                                               acc_addr_valid,
  output logic                                               acc_addr_ready,
  output logic [2*addr_bw+11:0]                              inst,
  output logic                                               sfp_clr,
  output logic                                               out_valid,
  output logic [((len_onij > 1) ? $clog2(len_onij) : 1)-1:0] out_idx,
  output logic                                               busy,
  output logic                                               done
);

  localparam int unsigned IW   = 2 * addr_bw + 12;
  localparam int unsigned OW   = (len_onij > 1) ? $clog2(len_onij) : 1;
  localparam int unsigned KW   = (len_kij > 1) ? $clog2(len_kij) : 1;
  localparam int unsigned TM0  = len_nij + row + col;
  localparam int unsigned TM1  = (gap > TM0) ? gap : TM0;
  localparam int unsigned TMAX = (len_kij > TM1) ? len_kij : TM1;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [1:0] MODE_CONV = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;

  localparam logic [IW-1:0] IDLE_WORD = {1'b0, 1'b1, 1'b1, {addr_bw{1'b0}},
                                         1'b1, 1'b1, {addr_bw{1'b0}}, 7'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_W_FILL, S_W_LOAD, S_GAP, S_A_FILL, S_EXEC, S_DRAIN,
    S_ACC_CLR, S_ACC_RD, S_ACC_TAIL, S_ACC_OUT, S_FIN
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     t, t_n;
  logic [KW-1:0]     k, k_n;
  logic [OW-1:0]     p, p_n;
  logic [1:0]        mode_q, mode_n;
  logic [31:0]       t32, k32, p32;

  logic              acc_c, cen_p_c, wen_p_c, cen_x_c, wen_x_c;
  logic [addr_bw-1:0] a_p_c, a_x_c;
  logic              ofifo_rd_c, ififo_wr_c, ififo_rd_c, l0_rd_c, l0_wr_c, execute_c, load_c;
  logic              sfp_clr_c, out_valid_c, done_c;
  logic [OW-1:0]     out_idx_c;
  logic [IW-1:0]     inst_c;

  assign t32 = 32'(t);
  assign k32 = 32'(k);
  assign p32 = 32'(p);

  // Next-state and instruction-field decode for the current state and phase counter
  always_comb begin
    state_n     = state;
    t_n         = t + TW'(1);
    k_n         = k;
    p_n         = p;
    mode_n      = mode_q;
    acc_c       = 1'b0;
    cen_p_c     = 1'b1;
    wen_p_c     = 1'b1;
    a_p_c       = '0;
    cen_x_c     = 1'b1;
    wen_x_c     = 1'b1;
    a_x_c       = '0;
    ofifo_rd_c  = 1'b0;
    ififo_wr_c  = 1'b0;
    ififo_rd_c  = 1'b0;
    l0_rd_c     = 1'b0;
    l0_wr_c     = 1'b0;
    execute_c   = 1'b0;
    load_c      = 1'b0;
    sfp_clr_c   = 1'b0;
    out_valid_c = 1'b0;
    out_idx_c   = out_idx;
    done_c      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_n  = mode;
          k_n     = '0;
          p_n     = '0;
          state_n = (mode == MODE_ACC) ? S_ACC_CLR : S_W_FILL;
        end
      end
      S_W_FILL: begin
        if (t32 < col) begin
          cen_x_c = 1'b0;
          a_x_c   = addr_bw'(w_base + k32 * col + t32);
        end
        // SRAM read data lands one cycle after the address
        ififo_wr_c = (t32 >= 1);
        if (t32 == col) state_n = S_W_LOAD;
      end
      S_W_LOAD: begin
        ififo_rd_c = 1'b1;
        load_c     = 1'b1;
        if (t32 == row + col - 1) state_n = S_GAP;
      end
      S_GAP: begin
        if (t32 == gap - 1) state_n = S_A_FILL;
      end
      S_A_FILL: begin
        if (t32 < len_nij) begin
          cen_x_c = 1'b0;
          a_x_c   = addr_bw'(t32);
        end
        l0_wr_c = (t32 >= 1);
        if (t32 == len_nij) state_n = S_EXEC;
      end
      S_EXEC: begin
        l0_rd_c   = 1'b1;
        execute_c = 1'b1;
        if (t32 == len_nij + row + col - 1) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        t_n = t;
        if (ofifo_valid) begin
          ofifo_rd_c = 1'b1;
          cen_p_c    = 1'b0;
          wen_p_c    = 1'b0;
          a_p_c      = addr_bw'(k32 * len_nij + t32);
          t_n        = t + TW'(1);
          if (t32 == len_nij - 1) begin
            if (k32 < len_kij - 1) begin
              k_n     = k + KW'(1);
              state_n = S_W_FILL;
            end else begin
              state_n = (mode_q == MODE_CONV) ? S_FIN : S_ACC_CLR;
            end
          end
        end
      end
      S_ACC_CLR: begin
        sfp_clr_c = 1'b1;
        state_n   = S_ACC_RD;
      end
      S_ACC_RD: begin
        t_n = t;
        if (acc_addr_valid) begin
          cen_p_c = 1'b0;
          a_p_c   = acc_addr;
          acc_c   = (t != '0);
          t_n     = t + TW'(1);
          if (t32 == len_kij - 1) state_n = S_ACC_TAIL;
        end
      end
      S_ACC_TAIL: begin
        // Folds in the data returned by the last psum read
        acc_c   = 1'b1;
        state_n = S_ACC_OUT;
      end
      S_ACC_OUT: begin
        out_valid_c = 1'b1;
        out_idx_c   = p;
        if (p32 == len_onij - 1) begin
          state_n = S_FIN;
        end else begin
          p_n     = p + OW'(1);
          state_n = S_ACC_CLR;
        end
      end
      S_FIN: begin
        done_c  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != state) t_n = '0;

    inst_c = {acc_c, cen_p_c, wen_p_c, a_p_c, cen_x_c, wen_x_c, a_x_c,
              ofifo_rd_c, ififo_wr_c, ififo_rd_c, l0_rd_c, l0_wr_c, execute_c, load_c};
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      t              <= '0;
      k              <= '0;
      p              <= '0;
      mode_q         <= '0;
      inst           <= IDLE_WORD;
      sfp_clr        <= 1'b0;
      out_valid      <= 1'b0;
      out_idx        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      acc_addr_ready <= 1'b0;
    end else begin
      state          <= state_n;
      t              <= t_n;
      k              <= k_n;
      p              <= p_n;
      mode_q         <= mode_n;
      inst           <= inst_c;
      sfp_clr        <= sfp_clr_c;
      out_valid      <= out_valid_c;
      out_idx        <= out_idx_c;
      busy           <= (state_n != S_IDLE);
      done           <= done_c;
      acc_addr_ready <= (state_n == S_ACC_RD);
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: a flat expected-instruction plan per run, consumed one entry per
// cycle except where a read waits on ofifo_valid / acc_addr_valid.
module tb_core_seq;

  localparam int ROW = 8, COL = 8, NIJ = 36, ONIJ = 16, KIJ = 9, ABW = 11, WB = 1024, GAP = 10;
  localparam int IW = 34, OW = 4;
  localparam logic [IW-1:0] IDLE_W = 34'h1_800C_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, ofifo_valid, acc_addr_valid;
  logic [1:0]      mode;
  logic [ABW-1:0]  acc_addr;
  logic            acc_addr_ready, sfp_clr, out_valid, busy, done;
  logic [IW-1:0]   inst;
  logic [OW-1:0]   out_idx;

  core_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ofifo_valid(ofifo_valid),
    .acc_addr(acc_addr), .acc_addr_valid(acc_addr_valid), .acc_addr_ready(acc_addr_ready),
    .inst(inst), .sfp_clr(sfp_clr), .out_valid(out_valid), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  // kind: 0 unconditional, 1 waits on ofifo_valid, 2 waits on acc_addr_valid
  typedef struct {
    logic [IW-1:0] inst;
    logic          clr;
    logic          ov;
    logic [OW-1:0] oidx;
    logic          dn;
    int            kind;
  } step_t;

  typedef struct {
    logic [1:0] mode;
    int         sm;
    int         nom;
    int         outs;
    int         wr;
    int         rd;
  } vec_t;

  step_t plan[$];
  vec_t  tbl[7];

  int n_err = 0, n_chk = 0;
  bit running;
  int pi, stalls;
  logic [OW-1:0] last_idx;
  logic [IW-1:0] e_inst;
  logic e_clr, e_ov, e_busy, e_done, e_rdy;
  logic [OW-1:0] e_oidx;
  int r_busy, r_out, r_wr, r_rd, r_done;
  logic [IW-1:0] second_inst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [IW-1:0] word(input logic acc, input logic cenp, input logic wenp,
                                         input logic [ABW-1:0] ap, input logic cenx,
                                         input logic wenx, input logic [ABW-1:0] ax,
                                         input logic [6:0] ctl);
    return {acc, cenp, wenp, ap, cenx, wenx, ax, ctl};
  endfunction

  task automatic push(input logic [IW-1:0] w, input logic clr, input logic ov,
                      input logic [OW-1:0] oidx, input logic dn, input int kind);
    step_t s;
    s.inst = w; s.clr = clr; s.ov = ov; s.oidx = oidx; s.dn = dn; s.kind = kind;
    plan.push_back(s);
  endtask

  // Whole-run instruction list assuming no stalls
  task automatic build(input logic [1:0] m);
    plan.delete();
    if (m != 2'b10) begin
      for (int k = 0; k < KIJ; k++) begin
        for (int t = 0; t <= COL; t++)
          push(word(1'b0, 1'b1, 1'b1, '0, (t < COL) ? 1'b0 : 1'b1, 1'b1,
                    (t < COL) ? 11'(WB + k * COL + t) : 11'd0, (t >= 1) ? 7'h20 : 7'h00),
               1'b0, 1'b0, '0, 1'b0, 0);
        for (int t = 0; t < ROW + COL; t++)
          push(word(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 7'h11), 1'b0, 1'b0, '0, 1'b0, 0);
        for (int t = 0; t < GAP; t++)
          push(IDLE_W, 1'b0, 1'b0, '0, 1'b0, 0);
        for (int t = 0; t <= NIJ; t++)
          push(word(1'b0, 1'b1, 1'b1, '0, (t < NIJ) ? 1'b0 : 1'b1, 1'b1,
                    (t < NIJ) ? 11'(t) : 11'd0, (t >= 1) ? 7'h04 : 7'h00),
               1'b0, 1'b0, '0, 1'b0, 0);
        for (int t = 0; t < NIJ + ROW + COL; t++)
          push(word(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 7'h0A), 1'b0, 1'b0, '0, 1'b0, 0);
        for (int n = 0; n < NIJ; n++)
          push(word(1'b0, 1'b0, 1'b0, 11'(k * NIJ + n), 1'b1, 1'b1, '0, 7'h40),
               1'b0, 1'b0, '0, 1'b0, 1);
      end
    end
    if (m != 2'b01) begin
      for (int p = 0; p < ONIJ; p++) begin
        push(IDLE_W, 1'b1, 1'b0, '0, 1'b0, 0);
        for (int j = 0; j < KIJ; j++)
          push(word((j != 0), 1'b0, 1'b1, '0, 1'b1, 1'b1, '0, 7'h00), 1'b0, 1'b0, '0, 1'b0, 2);
        push(word(1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 7'h00), 1'b0, 1'b0, '0, 1'b0, 0);
        push(IDLE_W, 1'b0, 1'b1, 4'(p), 1'b0, 0);
      end
    end
    push(IDLE_W, 1'b0, 1'b0, '0, 1'b1, 0);
  endtask

  // Expected outputs after the coming clock edge, given the inputs now driven
  task automatic model_step();
    step_t e;
    e_inst = IDLE_W; e_clr = 1'b0; e_ov = 1'b0; e_done = 1'b0;
    if (!reset) begin
      running = 1'b0;
      last_idx = '0;
    end else if (!running) begin
      if (start) begin
        build(mode);
        pi = 0;
        running = 1'b1;
      end
    end else begin
      e = plan[pi];
      if ((e.kind == 1 && !ofifo_valid) || (e.kind == 2 && !acc_addr_valid)) begin
        stalls++;
      end else begin
        e_inst = e.inst;
        if (e.kind == 2) e_inst[30:20] = acc_addr;
        e_clr = e.clr; e_ov = e.ov; e_done = e.dn;
        if (e.ov) last_idx = e.oidx;
        pi++;
        if (pi >= plan.size()) running = 1'b0;
      end
    end
    e_oidx = last_idx;
    e_busy = running;
    e_rdy  = 1'b0;
    if (running) e_rdy = (plan[pi].kind == 2);
  endtask

  task automatic check_cycle(input int cyc);
    logic [IW-1:0] a, r;
    a = inst; r = e_inst;
    if (r[19]) begin a[17:7] = '0; r[17:7] = '0; end
    if (r[32]) begin a[30:20] = '0; r[30:20] = '0; end
    chk($sformatf("cyc%0d", cyc),
        64'({a, sfp_clr, out_valid, out_idx, busy, done, acc_addr_ready}),
        64'({r, e_clr, e_ov, e_oidx, e_busy, e_done, e_rdy}));
  endtask

  task automatic drive(input int sm, input int cyc);
    acc_addr = 11'($urandom);
    case (sm)
      1: begin
        ofifo_valid    = ($urandom % 4) != 0;
        acc_addr_valid = ($urandom % 4) != 0;
      end
      2: begin
        ofifo_valid    = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        acc_addr_valid = !(((cyc % 12) >= 4) && ((cyc % 12) <= 6));
      end
      default: begin
        ofifo_valid    = 1'b1;
        acc_addr_valid = 1'b1;
      end
    endcase
  endtask

  // One run from start pulse to done (or to an injected reset at plan index rst_at)
  task automatic run(input logic [1:0] m, input int sm, input int rst_at);
    int cyc;
    r_busy = 0; r_out = 0; r_wr = 0; r_rd = 0; r_done = 0; stalls = 0;
    start = 1'b1; mode = m; reset = 1'b1;
    drive(sm, 0);
    cyc = 0;
    do begin
      reset = (rst_at >= 0 && running && pi == rst_at) ? 1'b0 : 1'b1;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_cycle(cyc);
      r_busy += int'(busy);
      r_out  += int'(out_valid);
      r_done += int'(done);
      if (!inst[32] && !inst[31]) r_wr++;
      if (!inst[32] && inst[31])  r_rd++;
      if (cyc == 1) second_inst = inst;
      cyc++;
      reset = 1'b1;
      start = running ? 1'($urandom) : 1'b0;
      mode  = running ? 2'($urandom) : m;
      drive(sm, cyc);
    end while (running && cyc < 20000);
    chk("end_idle", 64'(busy), 64'(0));
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'b00, 0, 1633, 16, 324, 144};
    tbl[1] = '{2'b01, 0, 1441,  0, 324,   0};
    tbl[2] = '{2'b10, 2,  193, 16,   0, 144};
    tbl[3] = '{2'b11, 1, 1633, 16, 324, 144};
    tbl[4] = '{2'b00, 2, 1633, 16, 324, 144};
    tbl[5] = '{2'b01, 1, 1441,  0, 324,   0};
    tbl[6] = '{2'b10, 1,  193, 16,   0, 144};

    reset = 1'b0; start = 1'b1; mode = 2'b00;
    ofifo_valid = 1'b1; acc_addr_valid = 1'b1; acc_addr = '0;
    running = 1'b0; pi = 0; stalls = 0; last_idx = '0;
    second_inst = '0;

    // Reset holds the sequencer idle even with start asserted
    for (int i = 0; i < 3; i++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_cycle(-1 - i);
    end
    chk("reset_inst", 64'(inst), 64'(IDLE_W));
    reset = 1'b1; start = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].mode, tbl[i].sm, -1);
      chk($sformatf("row%0d_busy", i), 64'(r_busy), 64'(tbl[i].nom + stalls));
      chk($sformatf("row%0d_outs", i), 64'(r_out), 64'(tbl[i].outs));
      chk($sformatf("row%0d_pwr", i), 64'(r_wr), 64'(tbl[i].wr));
      chk($sformatf("row%0d_prd", i), 64'(r_rd), 64'(tbl[i].rd));
      chk($sformatf("row%0d_done", i), 64'(r_done), 64'(1));
    end

    // Reset mid-EXEC of kij 4, then a fresh full run from kij 0
    run(2'b00, 1, 4 * 160 + 72 + 10);
    chk("rst_inst", 64'(inst), 64'(IDLE_W));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_done", 64'(r_done), 64'(0));
    run(2'b00, 0, -1);
    chk("restart_a_xmem", 64'(second_inst[17:7]), 64'(1024));
    chk("restart_cen_xmem", 64'(second_inst[19]), 64'(0));
    chk("restart_busy", 64'(r_busy), 64'(1633));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Hardware instruction sequencer that generates the 34-bit `inst` word driving `core` for a complete conv layer.
- Covers the per-kij weight L0/ififo fill, kernel load, activation L0 fill, execute, ofifo drain to psum memory, and the final SFP accumulation over output pixels.
- Parametrised in array size, feature-map size and kernel size.
- Adds run modes, ofifo back-pressure and an accumulation-address stream handshake.

Parameters:
- row, 8, PE rows (input channels)
- col, 8, PE columns (output channels)
- len_nij, 36, input pixels per tile
- len_onij, 16, output pixels
- len_kij, 9, kernel taps
- addr_bw, 11, xmem/pmem address width
- w_base, 1024, xmem base address of weights; kij k occupies w_base+k*col .. +col-1
- gap, 10, idle cycles after kernel load

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle run request; sampled only in IDLE
- mode  in  2  00 full layer, 01 conv only (no ACC), 10 accumulation only, 11 reserved (treated as 00)
- ofifo_valid  in  1  from core; ofifo holds a full row
- acc_addr  in  addr_bw  psum address for accumulation
- acc_addr_valid  in  1  acc_addr valid
- acc_addr_ready  out  1  sequencer consumes acc_addr this cycle
- inst  out  34  registered instruction word; bit map: 33 acc, 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem, 19 CEN_xmem, 18 WEN_xmem, 17:7 A_xmem, 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load
- sfp_clr  out  1  clears SFP accumulator before each output pixel
- out_valid  out  1  one-cycle pulse: sfp_out holds output pixel out_idx
- out_idx  out  $clog2(len_onij)  output pixel index
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Idle instruction word: CEN/WEN bits = 1, all other bits 0.
- Reset (reset==0 at posedge), from any state including mid-run:
  - state goes to IDLE;
  - inst = idle word;
  - sfp_clr, out_valid, done, busy, acc_addr_ready, out_idx, kij counter and phase counter t all = 0.
- All outputs are registered; the inst fields for state S and counter t appear on the cycle after the sequencer is in S with t.
- States and durations (kij counter k runs 0..len_kij-1; t resets to 0 on every state entry):
  - IDLE: on start, go to W_FILL if mode is 00/01/11, or to ACC_CLR if mode is 10. Start is ignored while busy.
  - W_FILL, col+1 cycles:
    - CEN_xmem=0 and WEN_xmem=1 for t<col;
    - A_xmem = w_base + k*col + t;
    - ififo_wr=1 for 1<=t<=col (one-cycle SRAM read latency).
  - W_LOAD, row+col cycles: ififo_rd=1, load=1.
  - GAP, gap cycles: idle word.
  - A_FILL, len_nij+1 cycles:
    - CEN_xmem=0 for t<len_nij;
    - A_xmem = t;
    - l0_wr=1 for 1<=t<=len_nij.
  - EXEC, len_nij+row+col cycles: l0_rd=1, execute=1.
  - DRAIN, len_nij reads:
    - a read cycle happens only when ofifo_valid==1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = k*len_nij + n, then n increments;
    - when ofifo_valid==0 the sequencer stalls with the idle word and n held.
    - After the last read: if k<len_kij-1, then k++ and go to W_FILL. Otherwise go to ACC_CLR (modes 00/11) or FIN (mode 01).
  - ACC_CLR, 1 cycle: sfp_clr=1.
  - ACC_RD, len_kij reads:
    - acc_addr_ready=1;
    - on a valid&&ready cycle: CEN_pmem=0, WEN_pmem=1, A_pmem=acc_addr, j increments;
    - acc bit = 1 on every read except j==0 (it accumulates the previous read's data);
    - when acc_addr_valid==0 the sequencer stalls with CEN_pmem=1 and acc=0.
  - ACC_TAIL, 1 cycle: acc=1, CEN_pmem=1.
  - ACC_OUT, 1 cycle: out_valid=1 with out_idx = current pixel p. If p==len_onij-1, go to FIN; otherwise p++ and go to ACC_CLR.
  - FIN, 1 cycle: done=1, then IDLE.
- A_pmem and A_xmem are truncated to addr_bw bits; no wrap checking (integrator must size them).
- Full-mode nominal run length: len_kij*(col+1 + row+col + gap + len_nij+1 + len_nij+row+col + len_nij) + len_onij*(len_kij+3) + 1 cycles (no stalls).

Test Plan:
- Default params, mode 00, ofifo_valid=1, acc_addr_valid=1 with addresses from a 144-entry table:
  - done pulses after 9*(9+16+10+37+52+36)+16*12+1 = 1633 cycles of busy;
  - 16 out_valid pulses with out_idx 0..15;
  - sfp_out matches golden out.txt when core is attached.
- Check inst trace for k=2:
  - W_FILL A_xmem runs 1040..1047;
  - ififo_wr high for exactly 8 cycles, lagging CEN_xmem by 1;
  - DRAIN A_pmem runs 72..107.
- Toggle ofifo_valid 1,0,0,1 during DRAIN:
  - ofifo_rd is never high while ofifo_valid==0;
  - still exactly 36 writes; A_pmem has no gaps.
- Mode 10 with acc_addr_valid low for 3 cycles mid-pixel:
  - no W/EXEC activity; first inst is sfp_clr;
  - exactly 9 pmem reads per pixel; acc held low during the stall.
- Assert reset=0 for 1 cycle during EXEC of k=4:
  - next cycle inst = idle word, busy=0;
  - a fresh start restarts at W_FILL with k=0, A_xmem=1024.
- Mode 01: done follows the last DRAIN read by 1 cycle; sfp_clr and out_valid never assert.
